// File: rtl/aes_key_sched_ctrl_if.sv
// Request and round-key stream signals between the AES-128 key-schedule controller,
// its requester and the cipher core.
interface aes_key_sched_ctrl_if #(
    parameter int KEY_W = 128
);
    logic             start;
    logic [KEY_W-1:0] key_in;
    logic             dir;
    logic             reuse;
    logic             rk_valid;
    logic             rk_ready;
    logic [KEY_W-1:0] rk_data;
    logic [3:0]       rk_idx;
    logic             rk_last;
    logic             busy;
    logic             cache_valid;

    modport master (
        output start, key_in, dir, reuse, rk_ready,
        input  rk_valid, rk_data, rk_idx, rk_last, busy, cache_valid
    );

    modport slave (
        input  start, key_in, dir, reuse, rk_ready,
        output rk_valid, rk_data, rk_idx, rk_last, busy, cache_valid
    );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Sequential AES-128 key schedule: expands one round key per cycle into a cache,
// then streams round keys 0..10 (encrypt) or 10..0 (decrypt) over valid/ready.
module aes_key_sched_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_W      = 128
) (
    input  logic                 clk,
    input  logic                 reset_n,
    aes_key_sched_ctrl_if.slave  bus
);
    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:15][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] round);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {RCON[round], 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_e;

    state_e           state_q, state_d;
    logic [3:0]       step_q, step_d;
    logic [3:0]       ptr_q, ptr_d;
    logic             dir_q, dir_d;
    logic             cache_valid_q, cache_valid_d;
    logic [KEY_W-1:0] rk_mem_q [NUM_ROUNDS+1];

    logic             mem_we;
    logic [3:0]       mem_addr;
    logic [KEY_W-1:0] mem_wdata;
    logic [KEY_W-1:0] prev_key;
    logic             rk_valid;
    logic             rk_last;

    assign rk_valid = (state_q == STREAM);
    assign rk_last  = rk_valid && (ptr_q == (dir_q ? 4'd0 : LAST_IDX));
    assign prev_key = rk_mem_q[step_q - 4'd1];

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        step_d        = step_q;
        ptr_d         = ptr_q;
        dir_d         = dir_q;
        cache_valid_d = cache_valid_q;
        mem_we        = 1'b0;
        mem_addr      = step_q;
        mem_wdata     = next_key(prev_key, step_q);

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dir_d = bus.dir;
                    if (bus.reuse && cache_valid_q) begin
                        ptr_d   = bus.dir ? LAST_IDX : 4'd0;
                        state_d = STREAM;
                    end else begin
                        mem_we        = 1'b1;
                        mem_addr      = 4'd0;
                        mem_wdata     = bus.key_in;
                        cache_valid_d = 1'b0;
                        step_d        = 4'd1;
                        state_d       = EXPAND;
                    end
                end
            end
            EXPAND: begin
                mem_we = 1'b1;
                step_d = step_q + 4'd1;
                if (step_q == LAST_IDX) begin
                    cache_valid_d = 1'b1;
                    step_d        = 4'd0;
                    ptr_d         = dir_q ? LAST_IDX : 4'd0;
                    state_d       = STREAM;
                end
            end
            STREAM: begin
                // The pointer is frozen on the final beat so it never leaves 0..10.
                if (bus.rk_ready) begin
                    if (rk_last) state_d = IDLE;
                    else         ptr_d   = dir_q ? (ptr_q - 4'd1) : (ptr_q + 4'd1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            step_q        <= 4'd0;
            ptr_q         <= 4'd0;
            dir_q         <= 1'b0;
            cache_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            ptr_q         <= ptr_d;
            dir_q         <= dir_d;
            cache_valid_q <= cache_valid_d;
        end
    end

    // NOTE: the key cache has no reset; cache_valid alone says whether its contents mean anything.
    always_ff @(posedge clk) begin
        if (mem_we) rk_mem_q[mem_addr] <= mem_wdata;
    end

    assign bus.rk_valid    = rk_valid;
    assign bus.rk_data     = rk_valid ? rk_mem_q[ptr_q] : '0;
    assign bus.rk_idx      = rk_valid ? ptr_q : 4'd0;
    assign bus.rk_last     = rk_last;
    assign bus.busy        = (state_q != IDLE);
    assign bus.cache_valid = cache_valid_q;
endmodule
